// File: rtl/encoder_4_2_irq.sv
// Sequential 4-to-2 priority encoder: latches request pulses into a pending set and hands out the winning index.
// Latency: request sampled at edge N -> pending after N -> valid/out after N+1; one code per 2 cycles max.
// Backpressure: out/valid hold while ready=0; new requests merge into pending and never disturb a presented code.
//
// Ports:
//   clk      rising-edge clock for all state
//   rst_n    asynchronous active-low reset (release synchronised externally)
//   enable   1 = inp is ORed into pending this edge, 0 = inp ignored
//   inp      four request lines (level or pulse)
//   ready    consumer accepts out when valid && ready at a rising edge
//   out      index of the served request, meaningful while valid=1
//   valid    out holds a code awaiting acceptance
//   pending  current pending register (observation only)
module encoder_4_2_irq #(
  // 1: bit 3 wins over bit 0; 0: bit 0 wins over bit 3
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [3:0] inp,
  input  logic       ready,
  output logic [1:0] out,
  output logic       valid,
  output logic [3:0] pending
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] PRESENT = 1'b1;

  logic [0:0] state_q, state_d;
  logic [3:0] pending_q, pending_d;
  logic [1:0] out_q, out_d;
  logic       valid_q, valid_d;

  logic       accept;
  logic [3:0] clr;
  logic [3:0] set;

  // Index of the winning pending bit. The later match in each loop wins,
  // so the scan direction encodes the priority order.
  function automatic logic [1:0] pick(input logic [3:0] p);
    logic [1:0] idx;
    idx = 2'b00;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 4; i++) begin
        if (p[i]) idx = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (p[i]) idx = 2'(i);
      end
    end
    return idx;
  endfunction

  assign accept = valid_q & ready;
  assign clr    = accept ? (4'b0001 << out_q) : 4'b0000;
  assign set    = enable ? inp : 4'b0000;

  // Set is applied after clear, so a re-request landing on the accept edge
  // survives and is served again.
  assign pending_d = (pending_q & ~clr) | set;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        // Selection looks only at the registered set, never at live inp,
        // which keeps every output a pure flop.
        if (pending_q != 4'b0000) begin
          out_d   = pick(pending_q);
          valid_d = 1'b1;
          state_d = PRESENT;
        end else begin
          valid_d = 1'b0;
        end
      end
      PRESENT: begin
        // out is frozen for the whole stall; it is left at its last value
        // after acceptance rather than being zeroed.
        if (ready) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 4'b0000;
      out_q     <= 2'b00;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      out_q     <= out_d;
      valid_q   <= valid_d;
    end
  end

  assign out     = out_q;
  assign valid   = valid_q;
  assign pending = pending_q;

endmodule
